// File: rtl/prco_wb_arbiter_pkg.sv
// Shared constants for the PRCO write-back arbiter: requester IDs,
// default register-set geometry and well-known register indices.
package prco_wb_arbiter_pkg;

   localparam int NREGS_DEF = 8;
   localparam int SELW_DEF  = 3;
   localparam int DW_DEF    = 16;

   localparam int REG_SP = 7;
   localparam int REG_BP = 6;

   // Requester identity; WB_NONE marks a cycle without a grant.
   typedef enum logic [1:0] {
      WB_RAM  = 2'd0,
      WB_ALU  = 2'd1,
      WB_DBG  = 2'd2,
      WB_NONE = 2'd3
   } wb_req_e;

   // Requester that follows r in round-robin order (RAM -> ALU -> DBG -> RAM).
   function automatic wb_req_e wb_next(input wb_req_e r);
      wb_req_e n;
      case (r)
         WB_RAM:  n = WB_ALU;
         WB_ALU:  n = WB_DBG;
         default: n = WB_RAM;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/prco_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by a
// decode claim and cleared by the matching write-back. Also provides the
// operand busy lookups and a registered population count.
module prco_wb_arbiter_scoreboard
   import prco_wb_arbiter_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int SELW  = SELW_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            claim_i,
   input  logic [SELW-1:0] claim_sel_i,
   input  logic            clr_i,
   input  logic [SELW-1:0] clr_sel_i,
   input  logic [SELW-1:0] chk_a_i,
   input  logic [SELW-1:0] chk_b_i,
   input  logic [SELW-1:0] chk_dbg_i,
   output logic            claim_ok_o,
   output logic            busy_a_o,
   output logic            busy_b_o,
   output logic            busy_dbg_o,
   output logic [SELW:0]   pend_cnt_o
);

   logic [NREGS-1:0] sb_q, sb_d;
   logic [NREGS-1:0] set_mask, clr_mask;
   logic [SELW:0]    cnt_q, cnt_d;

   function automatic logic [SELW:0] popcount(input logic [NREGS-1:0] v);
      logic [SELW:0] c;
      c = '0;
      for (int i = 0; i < NREGS; i++) begin
         c = c + {{SELW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // A claim on a register that is still pending is refused, even when that
   // register is being written back this very cycle; decode retries next cycle.
   assign claim_ok_o = claim_i & ~sb_q[claim_sel_i];
   assign busy_a_o   = sb_q[chk_a_i];
   assign busy_b_o   = sb_q[chk_b_i];
   assign busy_dbg_o = sb_q[chk_dbg_i];
   assign pend_cnt_o = cnt_q;

   // Next scoreboard: clear the written-back register, then set the claimed one.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (claim_ok_o) set_mask[claim_sel_i] = 1'b1;
      if (clr_i)      clr_mask[clr_sel_i]   = 1'b1;
      sb_d  = (sb_q & ~clr_mask) | set_mask;
      cnt_d = popcount(sb_d);
   end

   // Scoreboard and its population count, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prco_wb_arbiter.sv
// PRCO write-back arbiter: shares the register set's single write port
// between RAM load, ALU result and debug poke requesters, and tracks
// outstanding destination registers for RAW hazard stalls.
// Build option PRCO_WB_RR_EN: round-robin arbitration instead of the
// default fixed priority RAM > ALU > DBG.
module prco_wb_arbiter
   import prco_wb_arbiter_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int SELW  = SELW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_alu_vld,
   input  logic [SELW-1:0] i_alu_sel,
   input  logic [DW-1:0]   i_alu_dat,
   output logic            q_alu_ack,
   input  logic            i_ram_vld,
   input  logic [SELW-1:0] i_ram_sel,
   input  logic [DW-1:0]   i_ram_dat,
   output logic            q_ram_ack,
   input  logic            i_dbg_vld,
   input  logic [SELW-1:0] i_dbg_sel,
   input  logic [DW-1:0]   i_dbg_dat,
   output logic            q_dbg_ack,
   input  logic            i_claim,
   input  logic [SELW-1:0] i_claim_sel,
   output logic            q_claim_ok,
   input  logic [SELW-1:0] i_chk_a,
   input  logic [SELW-1:0] i_chk_b,
   output logic            q_busy_a,
   output logic            q_busy_b,
   output logic            q_we,
   output logic [SELW-1:0] q_seld,
   output logic [DW-1:0]   q_datd,
   output logic [SELW:0]   q_pend_cnt
);

   logic            ram_elig, alu_elig, dbg_elig;
   logic            dbg_busy;
   logic            claim_ok_raw;
   wb_req_e         gnt;
   logic [SELW-1:0] gnt_sel;
   logic [DW-1:0]   gnt_dat;
   logic            clr_en;

   logic            we_q, we_d;
   logic [SELW-1:0] seld_q, seld_d;
   logic [DW-1:0]   datd_q, datd_d;

   // Nothing is granted while reset is held, so no requester sees an ack
   // for a write that reset is about to discard.
   assign ram_elig = i_ram_vld & ~i_reset;
   assign alu_elig = i_alu_vld & ~i_reset;
   // A poke to a register with a pending write would be overwritten by that
   // write, so it waits; it never blocks the other requesters meanwhile.
   assign dbg_elig = i_dbg_vld & ~dbg_busy & ~i_reset;

`ifdef PRCO_WB_RR_EN
   wb_req_e ptr_q, ptr_d;

   // Round-robin pointer: names the requester with the highest priority now.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) ptr_q <= WB_RAM;
      else         ptr_q <= ptr_d;
   end

   // Pointer moves to one past the winner; idle cycles leave it in place.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt != WB_NONE) ptr_d = wb_next(gnt);
   end

   // Grant: search eligible requesters starting at the pointer.
   always_comb begin
      gnt = WB_NONE;
      case (ptr_q)
         WB_ALU: begin
            if      (alu_elig) gnt = WB_ALU;
            else if (dbg_elig) gnt = WB_DBG;
            else if (ram_elig) gnt = WB_RAM;
         end
         WB_DBG: begin
            if      (dbg_elig) gnt = WB_DBG;
            else if (ram_elig) gnt = WB_RAM;
            else if (alu_elig) gnt = WB_ALU;
         end
         default: begin
            if      (ram_elig) gnt = WB_RAM;
            else if (alu_elig) gnt = WB_ALU;
            else if (dbg_elig) gnt = WB_DBG;
         end
      endcase
   end
`else
   // Grant: fixed priority, loads first so the memory stage never backs up.
   always_comb begin
      gnt = WB_NONE;
      if      (ram_elig) gnt = WB_RAM;
      else if (alu_elig) gnt = WB_ALU;
      else if (dbg_elig) gnt = WB_DBG;
   end
`endif

   // Acks, winner's sel/dat mux, and scoreboard clear for tracked writers.
   always_comb begin
      q_ram_ack = (gnt == WB_RAM);
      q_alu_ack = (gnt == WB_ALU);
      q_dbg_ack = (gnt == WB_DBG);
      clr_en    = (gnt == WB_RAM) || (gnt == WB_ALU);
      case (gnt)
         WB_RAM: begin
            gnt_sel = i_ram_sel;
            gnt_dat = i_ram_dat;
         end
         WB_ALU: begin
            gnt_sel = i_alu_sel;
            gnt_dat = i_alu_dat;
         end
         default: begin
            gnt_sel = i_dbg_sel;
            gnt_dat = i_dbg_dat;
         end
      endcase
   end

   // Write-port next state: sel/dat hold their last value on idle cycles.
   always_comb begin
      we_d   = (gnt != WB_NONE);
      seld_d = seld_q;
      datd_d = datd_q;
      if (we_d) begin
         seld_d = gnt_sel;
         datd_d = gnt_dat;
      end
   end

   // Registered write port feeding the register set directly.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         we_q   <= 1'b0;
         seld_q <= '0;
         datd_q <= '0;
      end else begin
         we_q   <= we_d;
         seld_q <= seld_d;
         datd_q <= datd_d;
      end
   end

   assign q_we       = we_q;
   assign q_seld     = seld_q;
   assign q_datd     = datd_q;
   assign q_claim_ok = claim_ok_raw & ~i_reset;

   prco_wb_arbiter_scoreboard #(
      .NREGS (NREGS),
      .SELW  (SELW)
   ) u_sb (
      .clk_i       (i_clk),
      .rst_i       (i_reset),
      .claim_i     (i_claim),
      .claim_sel_i (i_claim_sel),
      .clr_i       (clr_en),
      .clr_sel_i   (gnt_sel),
      .chk_a_i     (i_chk_a),
      .chk_b_i     (i_chk_b),
      .chk_dbg_i   (i_dbg_sel),
      .claim_ok_o  (claim_ok_raw),
      .busy_a_o    (q_busy_a),
      .busy_b_o    (q_busy_b),
      .busy_dbg_o  (dbg_busy),
      .pend_cnt_o  (q_pend_cnt)
   );

endmodule

// File: doc/prco_wb_arbiter.md
Name: prco_wb_arbiter

Overview:
Write-back arbiter and register scoreboard for the PRCO 8x16 register set. Shares the set's single write port (we/seld/datd) between three requesters: ALU result, RAM load result and debug/monitor poke. Tracks destination registers with outstanding writes so decode can stall on RAW hazards. Sits between execute/memory stages and prco_regs; its registered outputs drive the register set's write port directly.

Parameters:
NREGS, 8, number of architectural registers (scoreboard width)
SELW, 3, register select width (log2 NREGS)
DW, 16, data width

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; asynchronous, active-high
i_alu_vld  in  1  ALU write-back request
i_alu_sel  in  SELW  ALU destination register
i_alu_dat  in  DW  ALU result
q_alu_ack  out  1  ALU request granted this cycle (combinational)
i_ram_vld  in  1  RAM load write-back request
i_ram_sel  in  SELW  load destination
i_ram_dat  in  DW  load data
q_ram_ack  out  1  RAM request granted (combinational)
i_dbg_vld  in  1  debug register poke request
i_dbg_sel  in  SELW  poke destination
i_dbg_dat  in  DW  poke data
q_dbg_ack  out  1  debug request granted (combinational)
i_claim  in  1  decode reserves a destination register
i_claim_sel  in  SELW  register being reserved
q_claim_ok  out  1  reservation accepted (combinational)
i_chk_a  in  SELW  decode operand A select
i_chk_b  in  SELW  decode operand B select
q_busy_a  out  1  operand A has pending write (combinational)
q_busy_b  out  1  operand B has pending write (combinational)
q_we  out  1  register-set write enable (registered)
q_seld  out  SELW  register-set write select (registered)
q_datd  out  DW  register-set write data (registered)
q_pend_cnt  out  SELW+1  population count of scoreboard (registered)

Behaviour:
- Reset (async, active-high, any time incl. mid-grant): q_we=0, q_seld=0, q_datd=0, scoreboard=0, q_pend_cnt=0, RR pointer=0; in-flight requests dropped, requesters must re-present after release.
- At most one grant per cycle; ack asserted same cycle as vld; requester holds vld/sel/dat stable until ack.
- Fixed priority (default): RAM > ALU > DBG.
- DBG eligible only if scoreboard[i_dbg_sel]==0; an ineligible DBG is skipped, not blocking lower/other requesters.
- Granted request registered: next cycle q_we=1, q_seld/q_datd = granted sel/dat (latency 1). No grant -> q_we=0, q_seld/q_datd hold last value.
- Scoreboard: claim with scoreboard[i_claim_sel]==0 -> q_claim_ok=1, bit set next edge. Bit already set -> q_claim_ok=0, no change (decode stalls).
- Grant of ALU/RAM to register r clears scoreboard[r] on the same edge q_we is registered. Clearing a bit not set is legal (no-op).
- Simultaneous clear and claim of same r: q_claim_ok=0 (bit still set in current cycle); bit cleared at edge; claim retries next cycle.
- q_busy_a/b = scoreboard[i_chk_a/b] | (granted this cycle AND grant sel == chk) negated, i.e. a register being written back this cycle reports not busy — no: report busy until q_we has been issued; busy = scoreboard bit only.
- q_pend_cnt = popcount of scoreboard after update; range 0..NREGS.

Optional Feature:
PRCO_WB_RR_EN — defined: round-robin among eligible requesters; 2-bit pointer starts at RAM, advances to one past the granted requester after each grant, unchanged when no grant. Undefined: fixed priority RAM > ALU > DBG, no pointer state.

Decomposition:
- Shared package/include (inc/prco_constants.v): requester IDs (WB_RAM=0, WB_ALU=1, WB_DBG=2), NREGS/SELW/DW defaults, REG_SP/REG_BP indices.
- One natural sub-module: prco_wb_scoreboard (bit vector, claim/clear, busy lookups, popcount); arbitration and output register stay in top.

Test Plan:
- Reset: assert i_reset mid-cycle with RAM vld -> q_we=0, q_pend_cnt=0, all scoreboard busy=0 immediately (async).
- Priority: RAM(r2,0xBEEF), ALU(r3,0x1234), DBG(r4,0x00AA) all vld same cycle -> acks RAM, ALU, DBG in three consecutive cycles; q_we/q_seld/q_datd show r2/BEEF, r3/1234, r4/00AA one cycle after each ack.
- Scoreboard hazard: claim r5 -> q_claim_ok=1, q_busy_a=1 for chk_a=5, q_pend_cnt=1; second claim r5 -> q_claim_ok=0; ALU writes r5 -> busy clears, q_pend_cnt=0.
- Debug blocking: claim r1, DBG poke r1 vld, ALU idle -> q_dbg_ack=0 until ALU writes r1; DBG acked next cycle after clear.
- Clear/claim collision: r6 pending, RAM writes r6 and claim r6 same cycle -> q_claim_ok=0, bit cleared; claim repeated next cycle -> q_claim_ok=1, q_pend_cnt=1.
- PRCO_WB_RR_EN: RAM and ALU continuously vld for 6 cycles -> grants alternate RAM, ALU, RAM, ALU, ... (DBG idle skipped).
